// File: rtl/sprite_pkg.sv
// Shared types and helpers for the palettised sprite layer.
// rgb12_t packs a {r,g,b} pixel; addr_w sizes the sprite ROM address.
package sprite_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t BLACK_RGB = '{r: 4'h0, g: 4'h0, b: 4'h0};

  function automatic int addr_w(
    input int frames,
    input int w,
    input int h
  );
    int n;
    n = frames * w * h;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Reset-to-zero shift register of DEPTH stages, W bits wide.
// Ports: clk, rst (async high), din -> dout delayed DEPTH edges.
module pipe_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [DEPTH-1:0][W-1:0] sr_q;
  logic [DEPTH-1:0][W-1:0] sr_d;

  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/palette_sprite_renderer.sv
// Palettised sprite layer: position shadow regs, animation, ROM address
// stage and compositing over bg_rgb. Ports: VGA timing in, ROM/palette
// handshake, registered red/green/blue and hit out.
module palette_sprite_renderer
  import sprite_pkg::*;
#(
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32,
  parameter int FRAMES      = 4,
  parameter int IDX_W       = 4,
  parameter int SCALE_SHIFT = 0,
  parameter int TRANSP_IDX  = 0,
  parameter int FRAME_DIV   = 8,
  parameter int ROM_LAT     = 1,
  localparam int ADDR_W     = addr_w(FRAMES, SPR_W, SPR_H)
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              pos_valid,
  input  logic              anim_en,
  input  logic              flip_h,
  input  logic [11:0]       bg_rgb,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [11:0]       pal_rgb,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              hit
);

  localparam int XW    = $clog2(SPR_W);
  localparam int YW    = $clog2(SPR_H);
  localparam int FW    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int DW    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int BOX_W = SPR_W << SCALE_SHIFT;
  localparam int BOX_H = SPR_H << SCALE_SHIFT;

  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPR_W * SPR_H);
  localparam logic [FW-1:0]     LAST_FR  = FW'(FRAMES - 1);
  localparam logic [DW-1:0]     LAST_DIV = DW'(FRAME_DIV - 1);
  localparam logic [IDX_W-1:0]  T_IDX    = IDX_W'(TRANSP_IDX);

  // position shadow and animation state
  logic [9:0]    pend_x_q, pend_x_d;
  logic [9:0]    pend_y_q, pend_y_d;
  logic [9:0]    act_x_q,  act_x_d;
  logic [9:0]    act_y_q,  act_y_d;
  logic [FW-1:0] frame_q,  frame_d;
  logic [DW-1:0] div_q,    div_d;

  // address stage
  logic [ADDR_W-1:0] rom_address_q, rom_address_d;
  logic              in_box_q,      in_box_d;
  logic              blank_q,       blank_d;
  logic [11:0]       bg_q,          bg_d;

  // compositing stage
  rgb12_t rgb_q, rgb_d;
  logic   hit_q, hit_d;

  logic [10:0]   rx;
  logic [10:0]   ry;
  logic [XW-1:0] tx;
  logic [YW-1:0] ty;

  logic        in_box_al;
  logic        blank_al;
  logic [11:0] bg_al;
  logic        opaque;

  always_comb begin
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    act_x_d  = act_x_q;
    act_y_d  = act_y_q;
    frame_d  = frame_q;
    div_d    = div_q;
    if (pos_valid) begin
      pend_x_d = pos_x;
      pend_y_d = pos_y;
    end
    // active always takes the pre-write pending value
    if (frame_start) begin
      act_x_d = pend_x_q;
      act_y_d = pend_y_q;
    end
    if (frame_start && anim_en) begin
      if (div_q == LAST_DIV) begin
        div_d   = '0;
        frame_d = (frame_q == LAST_FR) ? '0 : frame_q + FW'(1);
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  always_comb begin
    rx       = {1'b0, DrawX} - {1'b0, act_x_q};
    ry       = {1'b0, DrawY} - {1'b0, act_y_q};
    // bit 10 set means the pixel is left of / above the sprite
    in_box_d = !rx[10] && !ry[10] &&
               (rx < 11'(BOX_W)) && (ry < 11'(BOX_H));
    tx       = rx[SCALE_SHIFT +: XW];
    ty       = ry[SCALE_SHIFT +: YW];
    // SPR_W is a power of two, so SPR_W-1-tx is a bitwise invert
    if (flip_h) begin
      tx = ~tx;
    end
    rom_address_d = '0;
    if (in_box_d) begin
      rom_address_d = ADDR_W'(frame_q) * FRAME_SZ
                    + ADDR_W'({ty, tx});
    end
    blank_d = blank;
    bg_d    = bg_rgb;
  end

  // align box/blank/bg with rom_q
  pipe_delay #(
    .W     (14),
    .DEPTH (ROM_LAT)
  ) u_align (
    .clk  (vga_clk),
    .rst  (reset),
    .din  ({in_box_q, blank_q, bg_q}),
    .dout ({in_box_al, blank_al, bg_al})
  );

  always_comb begin
    opaque = in_box_al && (rom_q != T_IDX);
    rgb_d  = BLACK_RGB;
    hit_d  = 1'b0;
    if (blank_al) begin
      if (opaque) begin
        rgb_d = rgb12_t'(pal_rgb);
        hit_d = 1'b1;
      end else begin
        rgb_d = rgb12_t'(bg_al);
      end
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      pend_x_q      <= '0;
      pend_y_q      <= '0;
      act_x_q       <= '0;
      act_y_q       <= '0;
      frame_q       <= '0;
      div_q         <= '0;
      rom_address_q <= '0;
      in_box_q      <= 1'b0;
      blank_q       <= 1'b0;
      bg_q          <= '0;
      rgb_q         <= BLACK_RGB;
      hit_q         <= 1'b0;
    end else begin
      pend_x_q      <= pend_x_d;
      pend_y_q      <= pend_y_d;
      act_x_q       <= act_x_d;
      act_y_q       <= act_y_d;
      frame_q       <= frame_d;
      div_q         <= div_d;
      rom_address_q <= rom_address_d;
      in_box_q      <= in_box_d;
      blank_q       <= blank_d;
      bg_q          <= bg_d;
      rgb_q         <= rgb_d;
      hit_q         <= hit_d;
    end
  end

  assign rom_address = rom_address_q;
  assign pal_index   = rom_q;
  assign red         = rgb_q.r;
  assign green       = rgb_q.g;
  assign blue        = rgb_q.b;
  assign hit         = hit_q;

endmodule

// File: tb/tb_palette_sprite_renderer.sv
// Bench for palette_sprite_renderer: default instance plus a scaled,
// two-cycle-ROM instance, both checked against a pixel-level model.
module tb_palette_sprite_renderer;

  localparam int NC = 4096;

  logic        vga_clk = 1'b0;
  logic        reset   = 1'b1;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic        blank = 1'b0, frame_start = 1'b0;
  logic [9:0]  pos_x = '0, pos_y = '0;
  logic        pos_valid = 1'b0, anim_en = 1'b0, flip_h = 1'b0;
  logic [11:0] bg_rgb = '0;

  logic [11:0] ra1, ra2;
  logic [3:0]  pi1, pi2, rq1, rq2, rq2a;
  logic [11:0] pr1, pr2;
  logic [3:0]  r1, g1, b1, r2, g2, b2;
  logic        h1, h2;

  logic [3:0]  mem [4096];
  logic [11:0] pal [16];

  always #5 vga_clk = ~vga_clk;

  assign pr1 = pal[pi1];
  assign pr2 = pal[pi2];

  always @(posedge vga_clk) begin
    rq1  <= mem[ra1];
    rq2a <= mem[ra2];
    rq2  <= rq2a;
  end

  palette_sprite_renderer dut1 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_start(frame_start), .pos_x(pos_x),
    .pos_y(pos_y), .pos_valid(pos_valid), .anim_en(anim_en),
    .flip_h(flip_h), .bg_rgb(bg_rgb), .rom_address(ra1), .rom_q(rq1),
    .pal_index(pi1), .pal_rgb(pr1), .red(r1), .green(g1), .blue(b1),
    .hit(h1)
  );

  palette_sprite_renderer #(
    .SCALE_SHIFT(1), .ROM_LAT(2), .TRANSP_IDX(3)
  ) dut2 (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_start(frame_start), .pos_x(pos_x),
    .pos_y(pos_y), .pos_valid(pos_valid), .anim_en(anim_en),
    .flip_h(flip_h), .bg_rgb(bg_rgb), .rom_address(ra2), .rom_q(rq2),
    .pal_index(pi2), .pal_rgb(pr2), .red(r2), .green(g2), .blue(b2),
    .hit(h2)
  );

  // reference model state
  int pend_x, pend_y, act_x, act_y, pulses;
  int vectors, fails, cyc;
  logic [11:0] ea1 [NC];
  logic [11:0] ea2 [NC];
  logic [12:0] eo1 [NC];
  logic [12:0] eo2 [NC];

  logic        blank_v, flip_v, anim_v;
  logic [11:0] bg_v;
  int          posx_v, posy_v;

  function automatic int addr_of(int x, int y, logic fl, int s);
    int rx, ry, box, tx, ty, fr;
    box = 32 << s;
    rx  = x - act_x;
    ry  = y - act_y;
    if (rx < 0 || ry < 0 || rx >= box || ry >= box) return -1;
    tx = rx / (1 << s);
    ty = ry / (1 << s);
    if (fl) tx = 31 - tx;
    fr = (pulses / 8) % 4;
    return fr * 1024 + ty * 32 + tx;
  endfunction

  function automatic logic [12:0] out_of(int a, logic bl,
                                         logic [11:0] bg, int transp);
    if (!bl) return 13'd0;
    if (a >= 0 && int'(mem[a]) != transp) return {1'b1, pal[mem[a]]};
    return {1'b0, bg};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int x, input int y,
                      input logic fs, input logic pv);
    int a1, a2;
    logic rs;
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    frame_start = fs;
    pos_valid   = pv;
    pos_x       = 10'(posx_v);
    pos_y       = 10'(posy_v);
    blank       = blank_v;
    bg_rgb      = bg_v;
    flip_h      = flip_v;
    anim_en     = anim_v;
    rs = reset;
    a1 = addr_of(x, y, flip_v, 0);
    a2 = addr_of(x, y, flip_v, 1);
    @(posedge vga_clk);
    #1;
    cyc++;
    if (rs) begin
      ea1[cyc] = '0; ea2[cyc] = '0;
      eo1[cyc] = '0; eo2[cyc] = '0;
    end else begin
      ea1[cyc] = (a1 < 0) ? 12'd0 : 12'(a1);
      ea2[cyc] = (a2 < 0) ? 12'd0 : 12'(a2);
      eo1[cyc] = out_of(a1, blank_v, bg_v, 0);
      eo2[cyc] = out_of(a2, blank_v, bg_v, 3);
      if (fs) begin
        act_x = pend_x;
        act_y = pend_y;
        if (anim_v) pulses++;
      end
      if (pv) begin
        pend_x = posx_v;
        pend_y = posy_v;
      end
    end
    chk("addr1", 32'(ra1), 32'(ea1[cyc]));
    chk("addr2", 32'(ra2), 32'(ea2[cyc]));
    if (cyc >= 2) chk("pix1", 32'({h1, r1, g1, b1}), 32'(eo1[cyc-2]));
    if (cyc >= 3) chk("pix2", 32'({h2, r2, g2, b2}), 32'(eo2[cyc-3]));
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_pix1", 32'({h1, r1, g1, b1}), 32'd0);
    chk("rst_pix2", 32'({h2, r2, g2, b2}), 32'd0);
    chk("rst_addr", 32'(ra1), 32'd0);
    for (int i = 0; i < 4; i++) begin
      eo1[cyc-i] = '0;
      eo2[cyc-i] = '0;
    end
    pend_x = 0; pend_y = 0; act_x = 0; act_y = 0; pulses = 0;
  endtask

  initial begin
    int x, y;
    logic fs, pv;
    vectors = 0; fails = 0; cyc = 0;
    pend_x = 0; pend_y = 0; act_x = 0; act_y = 0; pulses = 0;
    for (int i = 0; i < NC; i++) begin
      ea1[i] = '0; ea2[i] = '0; eo1[i] = '0; eo2[i] = '0;
      mem[i] = 4'($urandom_range(0, 15));
    end
    for (int i = 0; i < 16; i++) pal[i] = 12'($urandom);
    mem[0]  = 4'd0;
    mem[31] = 4'd5;
    pal[5]  = 12'h5A3;
    blank_v = 1'b1; bg_v = 12'h123; flip_v = 1'b0; anim_v = 1'b0;
    posx_v = 100; posy_v = 50;

    repeat (3) step(0, 0, 1'b0, 1'b0);
    reset = 1'b0;
    step(0, 0, 1'b0, 1'b1);
    step(0, 0, 1'b1, 1'b0);

    // reset mid-line, then refill
    step(120, 50, 1'b0, 1'b0);
    step(125, 51, 1'b0, 1'b0);
    do_reset();
    repeat (3) step(110, 52, 1'b0, 1'b0);
    reset = 1'b0;
    step(700, 700, 1'b0, 1'b0);
    chk("refill1", 32'({h1, r1, g1, b1}), 32'd0);
    step(0, 0, 1'b0, 1'b0);
    chk("refill2", 32'({h1, r1, g1, b1}), 32'd0);
    step(0, 0, 1'b0, 1'b0);
    chk("first_valid", 32'({h1, r1, g1, b1}), 32'h0123);
    step(0, 0, 1'b0, 1'b1);
    step(0, 0, 1'b1, 1'b0);

    // box edges
    step(100, 50, 1'b0, 1'b0);
    chk("left_edge", 32'(ra1), 32'd0);
    step(131, 50, 1'b0, 1'b0);
    chk("right_texel", 32'(ra1), 32'd31);
    step(132, 50, 1'b0, 1'b0);
    chk("outside", 32'(ra1), 32'd0);
    step(133, 50, 1'b0, 1'b0);
    chk("hit_lat", 32'({h1, r1, g1, b1}), 32'h15A3);
    step(0, 0, 1'b0, 1'b0);
    chk("bg_pass", 32'({h1, r1, g1, b1}), 32'h0123);

    // flip and scale
    flip_v = 1'b1;
    step(100, 51, 1'b0, 1'b0);
    chk("flip", 32'(ra1), 32'd63);
    flip_v = 1'b0;
    step(103, 50, 1'b0, 1'b0);
    chk("scale", 32'(ra2), 32'd1);

    // transparent index and blanking
    bg_v = 12'hABC;
    step(100, 50, 1'b0, 1'b0);
    blank_v = 1'b0;
    step(100, 50, 1'b0, 1'b0);
    blank_v = 1'b1;
    step(0, 0, 1'b0, 1'b0);
    chk("transp", 32'({h1, r1, g1, b1}), 32'h0ABC);
    step(0, 0, 1'b0, 1'b0);
    chk("blanked", 32'({h1, r1, g1, b1}), 32'd0);

    // animation divider and wrap
    anim_v = 1'b1;
    repeat (8) step(0, 0, 1'b1, 1'b0);
    anim_v = 1'b0;
    step(101, 50, 1'b0, 1'b0);
    chk("frame1", 32'(ra1), 32'd1025);
    anim_v = 1'b1;
    repeat (24) step(0, 0, 1'b1, 1'b0);
    anim_v = 1'b0;
    step(101, 50, 1'b0, 1'b0);
    chk("frame_wrap", 32'(ra1), 32'd1);

    // pos write coincident with frame_start
    posx_v = 200; posy_v = 10;
    step(101, 50, 1'b1, 1'b1);
    step(101, 50, 1'b0, 1'b0);
    chk("old_pend", 32'(ra1), 32'd1);
    step(0, 0, 1'b1, 1'b0);
    step(201, 10, 1'b0, 1'b0);
    chk("new_pos", 32'(ra1), 32'd1);

    // randomized traffic
    repeat (800) begin
      fs = ($urandom_range(0, 39) == 0);
      pv = ($urandom_range(0, 7) == 0);
      if (pv) begin
        posx_v = ($urandom_range(0, 3) == 0) ?
                 int'($urandom_range(0, 1023)) :
                 int'($urandom_range(0, 600));
        posy_v = ($urandom_range(0, 3) == 0) ?
                 int'($urandom_range(0, 1023)) :
                 int'($urandom_range(0, 450));
      end
      anim_v  = 1'($urandom_range(0, 1));
      flip_v  = 1'($urandom_range(0, 1));
      blank_v = ($urandom_range(0, 7) != 0);
      bg_v    = 12'($urandom);
      x = (act_x + int'($urandom_range(0, 79)) - 8 + 1024) % 1024;
      y = (act_y + int'($urandom_range(0, 79)) - 8 + 1024) % 1024;
      step(x, y, fs, pv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
